tally_session_arbiter: RTL and testbench

- Shares one two-ones/two-zeros tally detector (inputs ONE/ZERO, synchronous active-high reset, output out) between two requesters.
- Grants one detection session at a time, round-robin, and clears the detector before each session.
- Muxes the granted requester's ONE/ZERO levels into the detector and ends each session on pass, timeout or abandon.
- Reports result and requester ID.

---
 rtl/tally_session_arbiter.sv | 158 +++++++++++++++
 tb/tb_tally_session_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tally_session_arbiter.sv
// Round-robin arbiter sharing one two-ones/two-zeros tally detector between two requesters.
// Optional per-requester pass counters are built when TALLY_PASS_COUNT_EN is defined.
module tally_session_arbiter #(
   parameter int TIMEOUT = 1000,
   parameter int TW      = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req,
   input  logic [1:0]  one_in,
   input  logic [1:0]  zero_in,
   input  logic        det_out,
   output logic        det_reset,
   output logic        det_one,
   output logic        det_zero,
   output logic [1:0]  grant,
   output logic        busy,
   output logic        done,
   output logic        pass,
`ifdef TALLY_PASS_COUNT_EN
   output logic [15:0] pass_count,
`endif
   output logic        result_id
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CLEAR  = 2'd1,
      ST_RUN    = 2'd2,
      ST_REPORT = 2'd3
   } state_t;

   localparam logic [TW-1:0] TIMEOUT_M1 = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

   state_t        state_r;
   logic          g_r;
   logic          last_served_r;
   logic          clr_cnt_r;
   logic [TW-1:0] timer_r;
   logic          one_mask_r;
   logic          zero_mask_r;
   logic          win_s;
   logic          exit_s;

   // Round-robin pick: a lone request wins, a tie goes to whoever was not served last
   always_comb begin
      win_s = 1'b0;
      case (req)
         2'b01:   win_s = 1'b0;
         2'b10:   win_s = 1'b1;
         2'b11:   win_s = ~last_served_r;
         default: win_s = 1'b0;
      endcase
   end

   // Session end condition: detector hit, timer expiry or the owner dropping its request
   always_comb begin
      if (det_out || (timer_r == TIMEOUT_M1) || !req[g_r]) begin
         exit_s = 1'b1;
      end else begin
         exit_s = 1'b0;
      end
   end

   // Session FSM with all detector-facing and status outputs registered
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= ST_IDLE;
         g_r           <= 1'b0;
         last_served_r <= 1'b1;
         clr_cnt_r     <= 1'b0;
         timer_r       <= {TW{1'b0}};
         one_mask_r    <= 1'b1;
         zero_mask_r   <= 1'b1;
         grant         <= 2'b00;
         det_reset     <= 1'b1;
         det_one       <= 1'b0;
         det_zero      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         result_id     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (req != 2'b00) begin
                  g_r       <= win_s;
                  grant     <= win_s ? 2'b10 : 2'b01;
                  busy      <= 1'b1;
                  clr_cnt_r <= 1'b0;
                  state_r   <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               one_mask_r  <= 1'b1;
               zero_mask_r <= 1'b1;
               if (clr_cnt_r) begin
                  det_reset <= 1'b0;
                  timer_r   <= {TW{1'b0}};
                  state_r   <= ST_RUN;
               end else begin
                  clr_cnt_r <= 1'b1;
               end
            end
            ST_RUN: begin
               // A level held since grant stays masked until it is seen low once
               one_mask_r  <= one_mask_r & one_in[g_r];
               zero_mask_r <= zero_mask_r & zero_in[g_r];
               if (exit_s) begin
                  pass      <= det_out;
                  done      <= 1'b1;
                  result_id <= g_r;
                  det_reset <= 1'b1;
                  det_one   <= 1'b0;
                  det_zero  <= 1'b0;
                  state_r   <= ST_REPORT;
               end else begin
                  timer_r  <= timer_r + TIMER_ONE;
                  det_one  <= one_in[g_r] & ~one_mask_r;
                  det_zero <= zero_in[g_r] & ~zero_mask_r;
               end
            end
            ST_REPORT: begin
               grant         <= 2'b00;
               busy          <= 1'b0;
               last_served_r <= g_r;
               state_r       <= ST_IDLE;
            end
            default: begin
               grant     <= 2'b00;
               det_reset <= 1'b1;
               det_one   <= 1'b0;
               det_zero  <= 1'b0;
               busy      <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef TALLY_PASS_COUNT_EN
   // Per-requester count of passing sessions, saturating at 255
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pass_count <= 16'h0000;
      end else if (done && pass) begin
         if (result_id) begin
            if (pass_count[15:8] != 8'hFF) pass_count[15:8] <= pass_count[15:8] + 8'h01;
         end else begin
            if (pass_count[7:0] != 8'hFF) pass_count[7:0] <= pass_count[7:0] + 8'h01;
         end
      end
   end
`endif

endmodule

// File: tb/tb_tally_session_arbiter.sv
// Directed bench for tally_session_arbiter with a behavioural tally detector and a
// result scoreboard; TIMEOUT is shortened to 16 cycles.
module tb_tally_session_arbiter;

   localparam int TIMEOUT = 16;
   localparam int TW      = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] req = 2'b00;
   logic [1:0] one_in = 2'b00;
   logic [1:0] zero_in = 2'b00;
   logic       det_out;
   logic       det_reset, det_one, det_zero, busy, done, pass, result_id;
   logic [1:0] grant;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int pushed   = 0;
   bit drop_on_done = 1'b0;
   logic [1:0] exp_q[$];

   tally_session_arbiter #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
      .clk(clk), .reset(reset), .req(req), .one_in(one_in), .zero_in(zero_in),
      .det_out(det_out), .det_reset(det_reset), .det_one(det_one), .det_zero(det_zero),
      .grant(grant), .busy(busy), .done(done), .pass(pass), .result_id(result_id)
   );

   always #5 clk = ~clk;

   // Behavioural detector: counts rising edges of ONE and ZERO, flags two of each
   logic       dq1, dq0, det_force = 1'b0;
   logic [1:0] ones_c, zeros_c;
   always_ff @(posedge clk) begin
      if (det_reset) begin
         dq1 <= 1'b0; dq0 <= 1'b0; ones_c <= 2'd0; zeros_c <= 2'd0;
      end else begin
         dq1 <= det_one;
         dq0 <= det_zero;
         if (det_one && !dq1 && ones_c != 2'd2) ones_c <= ones_c + 2'd1;
         if (det_zero && !dq0 && zeros_c != 2'd2) zeros_c <= zeros_c + 2'd1;
      end
   end
   assign det_out = ((ones_c == 2'd2) && (zeros_c == 2'd2)) | det_force;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest expected {pass, result_id}
   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_done", {31'd0, done}, 32'd0);
         end else begin
            check("session_result", {30'd0, pass, result_id}, {30'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic cycle();
      @(negedge clk);
      if (drop_on_done && done === 1'b1) req = 2'b00;
   endtask

   task automatic push(input logic p, input logic id);
      exp_q.push_back({p, id});
      pushed++;
   endtask

   task automatic wait_run(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         cycle();
         if (det_reset === 1'b0) seen = 1'b1;
      end
      check({tag, "_run_entry"}, {31'd0, seen}, 32'd1);
   endtask

   task automatic wait_done(input int bound, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         cycle();
         if (done === 1'b1) seen = 1'b1;
      end
      check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
   endtask

   initial begin
      int done_k;
      int cnt_before;
      // Reset held with random inputs
      #1 reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         req = 2'($urandom); one_in = 2'($urandom); zero_in = 2'($urandom);
      end
      @(negedge clk);
      check("rst_grant", {30'd0, grant}, 32'd0);
      check("rst_det_reset", {31'd0, det_reset}, 32'd1);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_pass", {31'd0, pass}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      req = 2'b00; one_in = 2'b00; zero_in = 2'b00; reset = 1'b1;
      repeat (3) cycle();
      check("idle_grant", {30'd0, grant}, 32'd0);
      check("idle_det_reset", {31'd0, det_reset}, 32'd1);
      check("idle_busy", {31'd0, busy}, 32'd0);

      // Round-robin from reset: 01, then 10, then 01
      req = 2'b11;
      push(1'b0, 1'b0);
      cycle();
      check("rr_first_grant", {30'd0, grant}, 32'h1);
      check("rr_busy", {31'd0, busy}, 32'd1);
      wait_done(30, "rr1");
      push(1'b0, 1'b1);
      cycle();
      check("rr_gap_grant", {30'd0, grant}, 32'd0);
      cycle();
      check("rr_second_grant", {30'd0, grant}, 32'h2);
      wait_done(30, "rr2");
      cycle();
      cycle();
      check("rr_third_grant", {30'd0, grant}, 32'h1);
      // Abandon: drop the request mid-RUN
      push(1'b0, 1'b0);
      wait_run("abandon");
      repeat (3) cycle();
      req = 2'b00;
      wait_done(4, "abandon");
      cycle();
      check("abandon_grant", {30'd0, grant}, 32'd0);

      // Pass path on requester 0
      drop_on_done = 1'b1;
      req = 2'b01;
      push(1'b1, 1'b0);
      wait_run("pass");
      for (int k = 0; k < 14; k++) begin
         if ((k >= 1 && k <= 3) || (k >= 7 && k <= 9)) begin
            one_in = 2'b01; zero_in = 2'b01;
         end else begin
            one_in = 2'b00; zero_in = 2'b00;
         end
         cycle();
      end
      check("pass_grant_idle", {30'd0, grant}, 32'd0);
      check("pass_held", {31'd0, pass}, 32'd1);
      check("pass_id_held", {31'd0, result_id}, 32'd0);

      // Timeout on requester 1 with a single ONE pulse
      req = 2'b10;
      push(1'b0, 1'b1);
      wait_run("timeout");
      done_k = -1;
      for (int k = 0; k < 20; k++) begin
         one_in = (k >= 1 && k <= 3) ? 2'b10 : 2'b00;
         cycle();
         if (done === 1'b1 && done_k < 0) done_k = k + 1;
      end
      one_in = 2'b00;
      check("timeout_latency", 32'(done_k), 32'(TIMEOUT));

      // Held ONE level at grant is masked until released
      one_in = 2'b01;
      req = 2'b01;
      push(1'b0, 1'b0);
      wait_run("held");
      for (int k = 0; k < 10; k++) begin
         check("held_det_one", {31'd0, det_one}, 32'd0);
         cycle();
      end
      one_in = 2'b00;
      cycle();
      one_in = 2'b01;
      cycle();
      check("rearm_det_one_high", {31'd0, det_one}, 32'd1);
      one_in = 2'b00;
      cycle();
      check("rearm_det_one_low", {31'd0, det_one}, 32'd0);
      wait_done(8, "held");

      // det_out rising on the last timer cycle wins over timeout
      req = 2'b10;
      push(1'b1, 1'b1);
      wait_run("prio");
      repeat (TIMEOUT - 1) cycle();
      det_force = 1'b1;
      cycle();
      det_force = 1'b0;
      check("prio_done", {31'd0, done}, 32'd1);
      check("prio_pass", {31'd0, pass}, 32'd1);

      // Reset mid-RUN: immediate reset values, no done
      cycle();
      req = 2'b01;
      wait_run("midrst");
      repeat (3) cycle();
      cnt_before = done_cnt;
      reset = 1'b0;
      #1;
      check("midrst_grant", {30'd0, grant}, 32'd0);
      check("midrst_det_reset", {31'd0, det_reset}, 32'd1);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_pass", {31'd0, pass}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      repeat (2) cycle();
      req = 2'b00;
      reset = 1'b1;
      repeat (4) cycle();
      check("midrst_no_done", 32'(done_cnt), 32'(cnt_before));
      check("sessions_reported", 32'(done_cnt), 32'(pushed));
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
